// File: rtl/memory_master_pkg.sv
// Shared types and defaults for the memory bus initiator and its tri-state memory.
package memory_master_pkg;

  localparam int unsigned AWidthDef = 5;
  localparam int unsigned DWidthDef = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrite   = 3'd1,
    StRdSetup = 3'd2,
    StRdData  = 3'd3,
    StResp    = 3'd4
  } state_e;

  function automatic logic is_read_phase(state_e st);
    return (st == StRdSetup) || (st == StRdData);
  endfunction

endpackage

// File: rtl/memory_master_if.sv
// Request/response channels plus the memory strobe/address pins of the bus initiator.
interface memory_master_if
  import memory_master_pkg::*;
#(
  parameter int unsigned AWidth = AWidthDef,
  parameter int unsigned DWidth = DWidthDef
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWidth-1:0] req_addr;
  logic [DWidth-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DWidth-1:0] rsp_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [AWidth-1:0] mem_addr;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, mem_wr, mem_rd, mem_addr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, mem_wr, mem_rd, mem_addr
  );

endinterface

// File: rtl/memory_master_iobuf.sv
// Tri-state pad for the shared memory data bus; keeps the 'z driver out of the FSM.
module memory_master_iobuf #(
  parameter int unsigned Width = 8
) (
  input  logic             oe_i,
  input  logic [Width-1:0] dout_i,
  inout  wire  [Width-1:0] pad_io,
  output logic [Width-1:0] din_o
);

  assign pad_io = oe_i ? dout_i : {Width{1'bz}};
  assign din_o  = pad_io;

endmodule

// File: rtl/memory_master.sv
// Single-transaction bus initiator for the strobe-based tri-state memory.
// Runs one write (1 bus cycle) or read (2 bus cycles) per request, then holds the response.
module memory_master
  import memory_master_pkg::*;
#(
  parameter int unsigned AWidth = AWidthDef,
  parameter int unsigned DWidth = DWidthDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  memory_master_if.master   bus,
  inout  wire  [DWidth-1:0] mem_data_io
);

  state_e state_q, state_d;

  logic              accept;
  logic [DWidth-1:0] din;

  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [AWidth-1:0] mem_addr_q, mem_addr_d;
  logic              oe_q, oe_d;
  logic [DWidth-1:0] dout_q, dout_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  assign bus.req_ready = (state_q == StIdle) && !rst_i;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = bus.req_we ? StWrite : StRdSetup;
        end
      end
      StWrite:   state_d = StResp;
      StRdSetup: state_d = StRdData;
      StRdData:  state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    mem_wr_d    = (state_d == StWrite);
    mem_rd_d    = is_read_phase(state_d);
    oe_d        = (state_d == StWrite);
    mem_addr_d  = accept ? bus.req_addr : mem_addr_q;
    dout_d      = (accept && bus.req_we) ? bus.req_wdata : dout_q;
    rsp_valid_d = (state_d == StResp);
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == StWrite) begin
      rsp_we_d    = 1'b1;
      rsp_rdata_d = '0;
    end else if (state_q == StRdData) begin
      rsp_we_d    = 1'b0;
      rsp_rdata_d = din;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  memory_master_iobuf #(
    .Width (DWidth)
  ) u_iobuf (
    .oe_i   (oe_q),
    .dout_i (dout_q),
    .pad_io (mem_data_io),
    .din_o  (din)
  );

endmodule
